systolic_tile_ctrl: RTL and testbench
=====================================

Name: systolic_tile_ctrl

Overview:
Sequencer for the 4x4 systolic datapath, which contains per-row input FIFOs, the systolic array and the result adder.
- Loads one tile of operands into the row FIFOs and issues row-skewed FIFO reads.
- Holds the array chip-select during the tile and waits for the array's done.
- Pulses accumulate strobes so that result_out is folded back into result_in across NUM tiles. This gives a K-tiled matrix multiply.

Parameters:
WIDTH, 32, operand width passed through to the FIFO data inputs
ROW, 4, array rows / number of row FIFOs
COL, 4, FIFO depth / beats loaded per row per tile
TW, 8, width of the tile-count input

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  start pulse, sampled in IDLE only
num_tiles  in  TW  tiles to accumulate; 0 is treated as 1
in_valid  in  1  operand beat valid
in_ready  out  1  operand beat accepted when in_valid&&in_ready
in_w  in  WIDTH  weight operand beat
in_i  in  WIDTH  input operand beat
data_in_w  out  WIDTH  to the datapath weight FIFOs
data_in_i  out  WIDTH  to the datapath input FIFOs
write  out  ROW  one-hot FIFO write enables
read  out  ROW  FIFO read enables, skewed per row
cs  out  1  array chip-select
dp_done  in  1  array done
acc_clr  out  1  clear the accumulator register that drives result_in
acc_en  out  1  load the accumulator from result_out
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when all tiles are complete
tile_idx  out  TW  index of the current tile
timeout_err  out  1  only present with CTRL_TIMEOUT_EN

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- Reset takes effect on any cycle, including mid-tile:
  - State goes to IDLE.
  - All outputs are 0, including tile_idx=0 and timeout_err=0.
  - Internal counters are cleared.
  - FIFO contents are not this block's responsibility.
- States: IDLE, LOAD, STREAM, WAIT, ACCUM, FIN.
- IDLE:
  - start=1 causes acc_clr to pulse for 1 cycle, latches ntiles=max(num_tiles,1), sets tile_idx=0 and goes to LOAD.
  - start in any other state is ignored.
- LOAD:
  - in_ready=1.
  - Beat counter k runs 0..ROW*COL-1.
  - On each accepted beat: write = one-hot(k/COL), registered so it aligns with the registered data_in_w=in_w and data_in_i=in_i.
  - write=0 on any cycle without an accepted beat.
  - After beat ROW*COL-1 is accepted: in_ready drops the next cycle and the state goes to STREAM.
  - in_valid gaps stall without a timeout.
- STREAM:
  - A cycle counter t runs 0..COL+ROW-2.
  - read[r] = (t>=r) && (t<r+COL).
  - Each row therefore receives exactly COL reads, with row r delayed by r cycles.
  - cs=1 from the first STREAM cycle until exit from WAIT.
  - After t=COL+ROW-2 the state goes to WAIT.
- WAIT:
  - read=0 and cs=1.
  - When dp_done=1 the state goes to ACCUM.
  - dp_done seen during STREAM is registered and honoured on WAIT entry, so it is not lost.
- ACCUM:
  - acc_en=1 for exactly 1 cycle and cs=0.
  - If tile_idx==ntiles-1, go to FIN.
  - Otherwise tile_idx increments and the state goes to LOAD.
- FIN: done=1 for 1 cycle, then IDLE.
- write and read are never both nonzero in the same cycle.
- acc_clr and acc_en are never asserted together.
- tile_idx does not wrap: the maximum is 2^TW-1 tiles.

Optional Feature:
CTRL_TIMEOUT_EN
- Defined:
  - A 16-bit counter runs in WAIT.
  - If it reaches 0xFFFF without dp_done, timeout_err is set (sticky until rst or the next start), cs=0, and the state goes to IDLE without done.
- Undefined:
  - The timeout_err port and counter are absent.
  - WAIT waits indefinitely.

Test Plan:
1. Basic tile:
   - Stimulus: rst, then start with num_tiles=1 and 16 back-to-back beats (in_w=k, in_i=100+k); dp_done 3 cycles after entering WAIT.
   - Response: write goes 0001 x4, 0010 x4, 0100 x4, 1000 x4. read[0] is high t=0..3 and read[3] is high t=3..6. Exactly 1 acc_en, then done 1 cycle later. busy=0 afterwards.
2. Accumulation:
   - Stimulus: num_tiles=3.
   - Response: acc_clr once at start, acc_en 3 times, tile_idx runs 0,1,2, a single done.
3. num_tiles=0 -> behaves exactly as num_tiles=1.
4. Valid gaps and ignored start:
   - Stimulus: in_valid toggles 1/0 during LOAD; start is pulsed during STREAM.
   - Response: still exactly 16 writes with no duplicates, and the start has no effect.
5. Early done and mid-tile reset:
   - Stimulus: dp_done pulses at STREAM t=2. Separately, rst is asserted during LOAD at beat 7.
   - Response: the early done is honoured, with acc_en on the cycle after WAIT entry. The rst gives IDLE next cycle with all outputs 0, and a new start runs cleanly.
6. With CTRL_TIMEOUT_EN:
   - Stimulus: dp_done is never asserted.
   - Response: timeout_err=1 after 65535 WAIT cycles, cs=0, no done, IDLE; the next start clears timeout_err.

Source files
------------

// File: rtl/systolic_tile_ctrl.sv
// systolic_tile_ctrl: sequencer for a ROW x COL systolic tile. It loads one tile
// of operands into the row FIFOs, streams row-skewed FIFO reads into the array,
// waits for the array's done and strobes the accumulator, once per tile.
// Optional feature macro: CTRL_TIMEOUT_EN adds a WAIT watchdog and the timeout_err port.
module systolic_tile_ctrl #(
  parameter int WIDTH = 32,
  parameter int ROW   = 4,
  parameter int COL   = 4,
  parameter int TW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [TW-1:0]    num_tiles,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_w,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] data_in_w,
  output logic [WIDTH-1:0] data_in_i,
  output logic [ROW-1:0]   write,
  output logic [ROW-1:0]   read,
  output logic             cs,
  input  logic             dp_done,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             busy,
  output logic             done,
`ifdef CTRL_TIMEOUT_EN
  output logic             timeout_err,
`endif
  output logic [TW-1:0]    tile_idx
);

  localparam int BEATS = ROW * COL;
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SLEN  = COL + ROW - 1;
  localparam int TCW   = $clog2(SLEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_WAIT,
    S_ACCUM,
    S_FIN
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [KW-1:0]   k;
  logic            load_full;
  logic [TCW-1:0]  t;
  logic            early_done;
  logic [TW-1:0]   ntiles;
  logic            accept;
  logic            last_tile;

  assign accept    = in_valid && in_ready;
  assign last_tile = (tile_idx == ntiles - TW'(1));

`ifdef CTRL_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        wait_timeout;

  // Fires on the 65535th consecutive WAIT cycle with no done from the array.
  assign wait_timeout = (state == S_WAIT) && !dp_done && !early_done &&
                        (wait_cnt == 16'hFFFE);

  // Watchdog counter for WAIT and the sticky error flag it raises.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_WAIT) wait_cnt <= wait_cnt + 16'd1;
      else                 wait_cnt <= '0;
      if (state == S_IDLE && start) timeout_err <= 1'b0;
      else if (wait_timeout)        timeout_err <= 1'b1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic and the outputs that follow directly from the state.
  // LOAD keeps one drain cycle with in_ready low after the last beat so the
  // registered write of that beat never shares a cycle with the first read.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    cs         = 1'b0;
    acc_en     = 1'b0;
    done       = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) next_state = S_LOAD;
      end
      S_LOAD: begin
        in_ready = !load_full;
        if (load_full) next_state = S_STREAM;
      end
      S_STREAM: begin
        cs = 1'b1;
        if (t == TCW'(SLEN - 1)) next_state = S_WAIT;
      end
      S_WAIT: begin
        cs = 1'b1;
        if (dp_done || early_done) next_state = S_ACCUM;
`ifdef CTRL_TIMEOUT_EN
        else if (wait_timeout) next_state = S_IDLE;
`endif
      end
      S_ACCUM: begin
        acc_en     = 1'b1;
        next_state = last_tile ? S_FIN : S_LOAD;
      end
      S_FIN: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Row-skewed FIFO reads: row r reads on stream cycles r .. r+COL-1.
  always_comb begin
    read = '0;
    if (state == S_STREAM) begin
      for (int r = 0; r < ROW; r++) begin
        read[r] = (int'(t) >= r) && (int'(t) < r + COL);
      end
    end
  end

  // Beat/stream counters, registered FIFO write path and tile bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      k          <= '0;
      load_full  <= 1'b0;
      t          <= '0;
      early_done <= 1'b0;
      ntiles     <= '0;
      tile_idx   <= '0;
      write      <= '0;
      data_in_w  <= '0;
      data_in_i  <= '0;
      acc_clr    <= 1'b0;
    end else begin
      write   <= '0;
      acc_clr <= 1'b0;
      if (accept) begin
        write     <= ROW'(1) << (int'(k) / COL);
        data_in_w <= in_w;
        data_in_i <= in_i;
        k         <= k + KW'(1);
        if (k == KW'(BEATS - 1)) load_full <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            acc_clr    <= 1'b1;
            ntiles     <= (num_tiles == '0) ? TW'(1) : num_tiles;
            tile_idx   <= '0;
            k          <= '0;
            load_full  <= 1'b0;
            early_done <= 1'b0;
          end
        end
        S_LOAD: begin
          t <= '0;
        end
        S_STREAM: begin
          t <= t + TCW'(1);
          if (dp_done) early_done <= 1'b1;
        end
        S_ACCUM: begin
          early_done <= 1'b0;
          k          <= '0;
          load_full  <= 1'b0;
          if (!last_tile) tile_idx <= tile_idx + TW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// tb_systolic_tile_ctrl: randomized self-checking bench for systolic_tile_ctrl
// against a transaction-level model of loads, skewed reads and tile strobes.
module tb_systolic_tile_ctrl;

  localparam int WIDTH = 32;
  localparam int ROW   = 4;
  localparam int COL   = 4;
  localparam int TW    = 8;
  localparam int BEATS = ROW * COL;
  localparam int SLEN  = COL + ROW - 1;
  localparam int EW    = ROW + 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [TW-1:0]    num_tiles;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_w;
  logic [WIDTH-1:0] in_i;
  logic [WIDTH-1:0] data_in_w;
  logic [WIDTH-1:0] data_in_i;
  logic [ROW-1:0]   write;
  logic [ROW-1:0]   read;
  logic             cs;
  logic             dp_done;
  logic             acc_clr;
  logic             acc_en;
  logic             busy;
  logic             done;
  logic [TW-1:0]    tile_idx;
`ifdef CTRL_TIMEOUT_EN
  logic             timeout_err;
`endif

  systolic_tile_ctrl #(.WIDTH(WIDTH), .ROW(ROW), .COL(COL), .TW(TW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles),
    .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w), .in_i(in_i),
    .data_in_w(data_in_w), .data_in_i(data_in_i), .write(write), .read(read),
    .cs(cs), .dp_done(dp_done), .acc_clr(acc_clr), .acc_en(acc_en),
    .busy(busy), .done(done),
`ifdef CTRL_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .tile_idx(tile_idx)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] expWr[$];
  logic [EW-1:0] actWr[$];
  int accEnCnt, accClrCnt, doneCnt, overlapCnt, clrEnCnt;
  int cycle = 0;
  int lastAccCyc, doneCyc;

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Advance one clock and sample the outputs 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    if (write != '0) actWr.push_back({write, data_in_w, data_in_i});
    if (write != '0 && read != '0) overlapCnt++;
    if (acc_clr && acc_en) clrEnCnt++;
    if (acc_en) begin accEnCnt++; lastAccCyc = cycle; end
    if (acc_clr) accClrCnt++;
    if (done) begin doneCnt++; doneCyc = cycle; end
  endtask

  // Offer beats until n are accepted; gapMode 0 none, 1 toggling, 2 random.
  task automatic feedBeats(input int n, input int dataMode, input int gapMode);
    int beats;
    int guard;
    logic acc;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] i;
    beats = 0;
    guard = 0;
    while (beats < n && guard < 200) begin
      case (gapMode)
        1:       in_valid = (guard % 2 == 0);
        2:       in_valid = ($urandom_range(0, 2) != 0);
        default: in_valid = 1'b1;
      endcase
      w = (dataMode == 0) ? WIDTH'(beats) : WIDTH'($urandom);
      i = (dataMode == 0) ? WIDTH'(100 + beats) : WIDTH'($urandom);
      in_w = w;
      in_i = i;
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        expWr.push_back({ROW'(1) << (beats / COL), w, i});
        beats++;
      end
      guard++;
    end
    in_valid = 1'b0;
    checkOutput("beats_accepted", beats, n);
  endtask

  // One complete job of nt tiles; doneOffFix<0 picks a random dp_done offset
  // counted from the first stream cycle.
  task automatic applyStimulus(input int nt, input int dataMode, input int gapMode,
                               input bit startInStream, input int doneOffFix);
    int nEff, doneOff, accOff, readMism, csMism, g, expAcc, seqMism;
    logic [ROW-1:0] expR;
    nEff = (nt == 0) ? 1 : nt;
    expWr.delete();
    actWr.delete();
    accEnCnt = 0; accClrCnt = 0; doneCnt = 0; overlapCnt = 0; clrEnCnt = 0;
    lastAccCyc = -100; doneCyc = -200;
    num_tiles = TW'(nt);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int tile = 0; tile < nEff; tile++) begin
      feedBeats(BEATS, dataMode, gapMode);
      g = 0;
      while (!cs && g < 10) begin tick(); g++; end
      checkOutput("cs_rise", cs, 1);
      if (!cs) return;
      doneOff  = (doneOffFix >= 0) ? doneOffFix : $urandom_range(0, SLEN + 5);
      readMism = 0;
      csMism   = 0;
      accOff   = -1;
      for (int off = 0; off < SLEN + 40; off++) begin
        if (acc_en) begin accOff = off; break; end
        for (int r = 0; r < ROW; r++) expR[r] = (off >= r) && (off < r + COL);
        if (read !== expR) readMism++;
        if (cs !== 1'b1) csMism++;
        dp_done = (off == doneOff);
        start   = startInStream && (off == 1);
        tick();
      end
      dp_done = 1'b0;
      start   = 1'b0;
      expAcc  = ((doneOff > SLEN) ? doneOff : SLEN) + 1;
      checkOutput("read_pattern", readMism, 0);
      checkOutput("cs_hold", csMism, 0);
      checkOutput("acc_offset", accOff, expAcc);
      checkOutput("tile_idx", tile_idx, tile);
      checkOutput("cs_drop", cs, 0);
      tick();
    end
    checkOutput("done_pulse", done, 1);
    checkOutput("done_after_acc", doneCyc - lastAccCyc, 1);
    tick();
    checkOutput("busy_after", busy, 0);
    checkOutput("done_count", doneCnt, 1);
    checkOutput("acc_en_count", accEnCnt, nEff);
    checkOutput("acc_clr_count", accClrCnt, 1);
    checkOutput("rw_overlap", overlapCnt, 0);
    checkOutput("clr_en_overlap", clrEnCnt, 0);
    checkOutput("write_count", actWr.size(), expWr.size());
    seqMism = 0;
    for (int j = 0; j < expWr.size() && j < actWr.size(); j++)
      if (actWr[j] !== expWr[j]) seqMism++;
    checkOutput("write_seq", seqMism, 0);
  endtask

  logic [2*WIDTH+3*ROW+TW+6:0] outVec;
  int csCycles;
  int gT;

  initial begin
    rst = 1'b1; start = 1'b0; num_tiles = '0; in_valid = 1'b0;
    in_w = '0; in_i = '0; dp_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    outVec = {busy, in_ready, cs, acc_clr, acc_en, done, 1'b0, write, read, write,
              tile_idx, data_in_w, data_in_i};
    checkOutput("reset_outputs", $countones(outVec), 0);

    $display("[TB] basic tile");
    applyStimulus(1, 0, 0, 1'b0, SLEN + 3);
    $display("[TB] three-tile accumulation");
    applyStimulus(3, 1, 0, 1'b0, -1);
    $display("[TB] num_tiles zero");
    applyStimulus(0, 1, 0, 1'b0, SLEN + 1);
    $display("[TB] valid gaps with start during stream");
    applyStimulus(2, 1, 1, 1'b1, -1);
    $display("[TB] early dp_done");
    applyStimulus(1, 1, 0, 1'b0, 2);

    $display("[TB] reset during load");
    num_tiles = TW'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    feedBeats(7, 1, 0);
    in_valid = 1'b1;
    in_w = WIDTH'($urandom);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    outVec = {busy, in_ready, cs, acc_clr, acc_en, done, 1'b0, write, read, write,
              tile_idx, data_in_w, data_in_i};
    checkOutput("midreset_outputs", $countones(outVec), 0);
    applyStimulus(1, 1, 0, 1'b0, -1);

    $display("[TB] random jobs");
    for (int n = 0; n < 3; n++)
      applyStimulus($urandom_range(1, 4), 1, 2, 1'($urandom_range(0, 1)), -1);

`ifdef CTRL_TIMEOUT_EN
    $display("[TB] watchdog");
    doneCnt = 0;
    num_tiles = TW'(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    feedBeats(BEATS, 1, 0);
    csCycles = 0;
    gT = 0;
    while (busy && gT < 70000) begin
      if (cs) csCycles++;
      tick();
      gT++;
    end
    checkOutput("timeout_cs_cycles", csCycles, SLEN + 65535);
    checkOutput("timeout_err_set", timeout_err, 1);
    checkOutput("timeout_idle", busy, 0);
    checkOutput("timeout_cs", cs, 0);
    checkOutput("timeout_no_done", doneCnt, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("timeout_err_cleared", timeout_err, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
